// File: rtl/grf_wb_pkg.sv
// Write-back encodings and fixed register numbers.
// Shared with the WB decoder and the forwarding unit.
package mips_defs;
    localparam logic [1:0] WT_ALU  = 2'd0;
    localparam logic [1:0] WT_DM   = 2'd1;
    localparam logic [1:0] WT_LINK = 2'd2;
    localparam logic [1:0] WT_RSVD = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;
endpackage

// File: rtl/grf_wb_wb_sel.sv
// Write-back datum select: ALU result, load data or link address.
// The reserved encoding yields zero.
module wb_sel
    import mips_defs::*;
#(
    parameter int DATA_W      = 32,
    parameter int LINK_OFFSET = 8
) (
    input  logic [1:0]        write_type,
    input  logic [DATA_W-1:0] alu_wb,
    input  logic [DATA_W-1:0] dm_wb,
    input  logic [DATA_W-1:0] pc_wb,
    output logic [DATA_W-1:0] wd
);
    logic [DATA_W-1:0] w_link;

    // Carry-out is discarded so the link address wraps around.
    assign w_link = pc_wb + DATA_W'(LINK_OFFSET);

    always_comb begin
        wd = '0;
        case (write_type)
            WT_ALU:  wd = alu_wb;
            WT_DM:   wd = dm_wb;
            WT_LINK: wd = w_link;
            default: wd = '0;
        endcase
    end
endmodule

// File: rtl/grf_wb.sv
// WB-stage register file: commits the selected datum and serves two read
// ports with same-cycle bypass, plus a one-cycle registered commit trace.
module grf_wb
    import mips_defs::*;
#(
    parameter int REG_NUM     = 32,
    parameter int DATA_W      = 32,
    parameter int LINK_OFFSET = 8,
    parameter int AW          = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              grf_we,
    input  logic [1:0]        write_type,
    input  logic [AW-1:0]     a3,
    input  logic [DATA_W-1:0] alu_wb,
    input  logic [DATA_W-1:0] dm_wb,
    input  logic [DATA_W-1:0] pc_wb,
    input  logic [AW-1:0]     a1,
    input  logic [AW-1:0]     a2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] wd_out,
    output logic              commit_valid,
    output logic [AW-1:0]     commit_addr,
    output logic [DATA_W-1:0] commit_data
);
    logic [DATA_W-1:0] r_regs [REG_NUM];
    logic [DATA_W-1:0] w_wd;
    logic              w_eff_we;

    wb_sel #(
        .DATA_W      (DATA_W),
        .LINK_OFFSET (LINK_OFFSET)
    ) u_wb_sel (
        .write_type (write_type),
        .alu_wb     (alu_wb),
        .dm_wb      (dm_wb),
        .pc_wb      (pc_wb),
        .wd         (w_wd)
    );

    assign wd_out = w_wd;

    // Reset gates the write so neither storage nor bypass sees it.
    assign w_eff_we = grf_we && (write_type != WT_RSVD)
                      && (a3 != AW'(REG_ZERO)) && !reset;

    assign rd1 = (a1 == AW'(REG_ZERO))       ? '0   :
                 (w_eff_we && (a1 == a3))    ? w_wd : r_regs[a1];
    assign rd2 = (a2 == AW'(REG_ZERO))       ? '0   :
                 (w_eff_we && (a2 == a3))    ? w_wd : r_regs[a2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
        end else if (w_eff_we) begin
            r_regs[a3] <= w_wd;
        end
    end

    // Address and data fields only move on a real commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_valid <= 1'b0;
            commit_addr  <= '0;
            commit_data  <= '0;
        end else begin
            commit_valid <= w_eff_we;
            if (w_eff_we) begin
                commit_addr <= a3;
                commit_data <= w_wd;
            end
        end
    end
endmodule

// File: tb/tb_grf_wb.sv
// Randomized and directed bench for grf_wb against a behavioural model
// of the register file and commit trace.
module tb_grf_wb;
    logic        clk = 1'b0;
    logic        reset, grf_we;
    logic [1:0]  write_type;
    logic [4:0]  a3, a1, a2;
    logic [31:0] alu_wb, dm_wb, pc_wb;
    logic [31:0] rd1, rd2, wd_out, commit_data;
    logic        commit_valid;
    logic [4:0]  commit_addr;

    int vecs = 0;
    int errs = 0;

    logic [31:0] mregs [32];
    logic        mvalid;
    logic [4:0]  maddr;
    logic [31:0] mdata;

    grf_wb dut (
        .clk          (clk),
        .reset        (reset),
        .grf_we       (grf_we),
        .write_type   (write_type),
        .a3           (a3),
        .alu_wb       (alu_wb),
        .dm_wb        (dm_wb),
        .pc_wb        (pc_wb),
        .a1           (a1),
        .a2           (a2),
        .rd1          (rd1),
        .rd2          (rd2),
        .wd_out       (wd_out),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_wd();
        case (write_type)
            2'd0:    return alu_wb;
            2'd1:    return dm_wb;
            2'd2:    return pc_wb + 32'd8;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_eff();
        return grf_we && (write_type != 2'd3) && (a3 != 5'd0) && !reset;
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_eff() && a == a3) return m_wd();
        return mregs[a];
    endfunction

    task automatic drive(input logic rst, input logic we, input logic [1:0] wt,
                         input logic [4:0] wa, input logic [31:0] alu,
                         input logic [31:0] dm, input logic [31:0] pc,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        reset = rst; grf_we = we; write_type = wt; a3 = wa;
        alu_wb = alu; dm_wb = dm; pc_wb = pc; a1 = ra1; a2 = ra2;
        #1;
    endtask

    // Advance one clock edge, updating the model from the inputs in force.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            mvalid = 1'b0; maddr = 5'd0; mdata = 32'd0;
        end else begin
            mvalid = m_eff();
            if (mvalid) begin
                maddr = a3; mdata = m_wd(); mregs[a3] = m_wd();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5, 31);
        vecs++; if (rd1 !== 32'd0) begin errs++; $display("FAIL reset_rd1 got %h want 0", rd1); end
        vecs++; if (rd2 !== 32'd0) begin errs++; $display("FAIL reset_rd2 got %h want 0", rd2); end
        vecs++; if (commit_valid !== 1'b0) begin errs++; $display("FAIL reset_cv got %b want 0", commit_valid); end
    endtask

    task automatic test_alu_bypass();
        drive(0, 1, 0, 8, 32'h12345678, 0, 0, 8, 0);
        vecs++; if (rd1 !== 32'h12345678) begin errs++; $display("FAIL alu_bypass got %h want 12345678", rd1); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 8, 0);
        vecs++; if (rd1 !== 32'h12345678) begin errs++; $display("FAIL alu_stored got %h want 12345678", rd1); end
        vecs++; if (commit_valid !== 1'b1) begin errs++; $display("FAIL alu_cv got %b want 1", commit_valid); end
        vecs++; if (commit_addr !== 5'd8) begin errs++; $display("FAIL alu_ca got %0d want 8", commit_addr); end
        vecs++; if (commit_data !== 32'h12345678) begin errs++; $display("FAIL alu_cd got %h want 12345678", commit_data); end
    endtask

    task automatic test_src_sel();
        drive(0, 1, 1, 9, 32'h1, 32'hDEADBEEF, 0, 0, 0);
        vecs++; if (wd_out !== 32'hDEADBEEF) begin errs++; $display("FAIL dm_wd got %h want deadbeef", wd_out); end
        tick();
        drive(0, 1, 2, 31, 32'h1, 32'h2, 32'h00003010, 0, 0);
        vecs++; if (wd_out !== 32'h00003018) begin errs++; $display("FAIL link_wd got %h want 00003018", wd_out); end
        tick();
        drive(0, 1, 2, 12, 32'h1, 32'h2, 32'hFFFFFFFC, 0, 0);
        vecs++; if (wd_out !== 32'h00000004) begin errs++; $display("FAIL link_wrap_wd got %h want 00000004", wd_out); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 9, 31);
        vecs++; if (rd1 !== 32'hDEADBEEF) begin errs++; $display("FAIL dm_read got %h want deadbeef", rd1); end
        vecs++; if (rd2 !== 32'h00003018) begin errs++; $display("FAIL link_read got %h want 00003018", rd2); end
        drive(0, 0, 0, 0, 0, 0, 0, 12, 0);
        vecs++; if (rd1 !== 32'h00000004) begin errs++; $display("FAIL wrap_read got %h want 00000004", rd1); end
    endtask

    task automatic test_zero_rsvd();
        drive(0, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        vecs++; if (rd1 !== 32'd0) begin errs++; $display("FAIL zero_bypass got %h want 0", rd1); end
        tick();
        vecs++; if (commit_valid !== 1'b0) begin errs++; $display("FAIL zero_cv got %b want 0", commit_valid); end
        drive(0, 1, 3, 4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 0);
        vecs++; if (wd_out !== 32'd0) begin errs++; $display("FAIL rsvd_wd got %h want 0", wd_out); end
        vecs++; if (rd1 !== 32'd0) begin errs++; $display("FAIL rsvd_bypass got %h want 0", rd1); end
        tick();
        vecs++; if (commit_valid !== 1'b0) begin errs++; $display("FAIL rsvd_cv got %b want 0", commit_valid); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 4);
        vecs++; if (rd1 !== 32'd0) begin errs++; $display("FAIL zero_read got %h want 0", rd1); end
        vecs++; if (rd2 !== 32'd0) begin errs++; $display("FAIL rsvd_read got %h want 0", rd2); end
    endtask

    task automatic test_write_in_reset();
        drive(0, 1, 0, 7, 32'h00000077, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 7, 32'hAAAA5555, 0, 0, 7, 0);
        vecs++; if (rd1 !== 32'h00000077) begin errs++; $display("FAIL rst_nobypass got %h want 00000077", rd1); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 7, 0);
        vecs++; if (rd1 !== 32'd0) begin errs++; $display("FAIL rst_drop got %h want 0", rd1); end
        vecs++; if (commit_valid !== 1'b0) begin errs++; $display("FAIL rst_cv got %b want 0", commit_valid); end
        vecs++; if (commit_data !== 32'd0) begin errs++; $display("FAIL rst_cd got %h want 0", commit_data); end
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 0, 10, 32'd1, 0, 0, 10, 10);
        vecs++; if (rd1 !== 32'd1 || rd2 !== 32'd1) begin errs++; $display("FAIL b2b_first got %h/%h want 1/1", rd1, rd2); end
        tick();
        drive(0, 1, 0, 10, 32'd2, 0, 0, 10, 10);
        vecs++; if (rd1 !== 32'd2 || rd2 !== 32'd2) begin errs++; $display("FAIL b2b_second got %h/%h want 2/2", rd1, rd2); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 10, 0);
        vecs++; if (rd1 !== 32'd2) begin errs++; $display("FAIL b2b_final got %h want 2", rd1); end
        vecs++; if (commit_addr !== 5'd10 || commit_data !== 32'd2) begin errs++; $display("FAIL b2b_trace got %0d/%h want 10/2", commit_addr, commit_data); end
    endtask

    task automatic test_random();
        logic [4:0] ra, rb, rw;
        for (int n = 0; n < 400; n++) begin
            // Narrow address range half the time to force port collisions.
            if ($urandom_range(0, 1) == 0) begin
                rw = 5'($urandom_range(0, 7)); ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7));
            end else begin
                rw = 5'($urandom); ra = 5'($urandom); rb = 5'($urandom);
            end
            drive(($urandom_range(0, 31) == 0), 1'($urandom), 2'($urandom), rw,
                  $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 | 32'($urandom_range(0, 7))) : $urandom,
                  ra, rb);
            vecs++; if (wd_out !== m_wd()) begin errs++; $display("FAIL rnd_wd n=%0d got %h want %h", n, wd_out, m_wd()); end
            vecs++; if (rd1 !== m_rd(a1)) begin errs++; $display("FAIL rnd_rd1 n=%0d a1=%0d got %h want %h", n, a1, rd1, m_rd(a1)); end
            vecs++; if (rd2 !== m_rd(a2)) begin errs++; $display("FAIL rnd_rd2 n=%0d a2=%0d got %h want %h", n, a2, rd2, m_rd(a2)); end
            tick();
            vecs++;
            if (commit_valid !== mvalid || commit_addr !== maddr || commit_data !== mdata) begin
                errs++;
                $display("FAIL rnd_trace n=%0d got %b/%0d/%h want %b/%0d/%h", n,
                         commit_valid, commit_addr, commit_data, mvalid, maddr, mdata);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mvalid = 1'b0; maddr = 5'd0; mdata = 32'd0;
        test_reset();
        test_alu_bypass();
        test_src_sel();
        test_zero_rsvd();
        test_write_in_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
